mem_wb_retire: RTL and testbench

Pipeline register between the MEM and WB stages of the 16-bit pipelined CPU, plus retirement bookkeeping. It selects the writeback value, gates the register-file write, and latches the sticky halt. It also keeps retired-instruction and cycle counters. Its outputs drive the register file write port, the top-level `hlt` pin, and the simulation trace hooks.

---
 rtl/mem_wb_retire.sv | 81 ++++++++
 tb/tb_mem_wb_retire.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_wb_retire.sv
// mem_wb_retire: MEM/WB stage register with writeback select, sticky halt and retirement counters
module mem_wb_retire #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze_i,
    input  logic             flush_i,
    input  logic             m_valid,
    input  logic             m_regwrite,
    input  logic             m_memtoreg,
    input  logic             m_memread,
    input  logic             m_memwrite,
    input  logic             m_halt,
    input  logic [3:0]       m_dst,
    input  logic [15:0]      m_alu,
    input  logic [15:0]      m_rdata,
    input  logic [15:0]      m_wdata,
    input  logic [15:0]      m_pc,
    output logic             wb_regwrite,
    output logic [3:0]       wb_dst,
    output logic [15:0]      wb_data,
    output logic             wb_memread,
    output logic             wb_memwrite,
    output logic [15:0]      wb_addr,
    output logic [15:0]      wb_sdata,
    output logic [15:0]      wb_pc,
    output logic             hlt,
    output logic [CNT_W-1:0] inst_count,
    output logic [CNT_W-1:0] cycle_count
);
    logic        valid, regwrite, memread, memwrite, halt, fresh;
    logic [3:0]  dst;
    logic [15:0] data, addr, sdata, pc;
    logic        cap, nv;
    assign cap = ~freeze_i & ~hlt;
    assign nv  = m_valid & ~flush_i;
    // A captured halt blocks all later captures, so valid & halt stays set until reset
    assign hlt = valid & halt;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            regwrite    <= 1'b0;
            memread     <= 1'b0;
            memwrite    <= 1'b0;
            halt        <= 1'b0;
            fresh       <= 1'b0;
            dst         <= '0;
            data        <= '0;
            addr        <= '0;
            sdata       <= '0;
            pc          <= '0;
            inst_count  <= '0;
            cycle_count <= '0;
        end else begin
            if (!hlt) cycle_count <= cycle_count + CNT_W'(1);
            fresh <= cap;
            if (cap) begin
                valid      <= nv;
                regwrite   <= nv & m_regwrite;
                memread    <= nv & m_memread;
                memwrite   <= nv & m_memwrite;
                halt       <= nv & m_halt;
                dst        <= m_dst;
                data       <= m_memtoreg ? m_rdata : m_alu;
                addr       <= m_alu;
                sdata      <= m_wdata;
                pc         <= m_pc;
                inst_count <= inst_count + CNT_W'(nv & (m_regwrite | m_memwrite | m_halt));
            end
        end
    end
    assign wb_regwrite = valid & regwrite & fresh & (dst != 4'd0);
    assign wb_memread  = valid & fresh & memread;
    assign wb_memwrite = valid & fresh & memwrite;
    assign wb_dst      = dst;
    assign wb_data     = data;
    assign wb_addr     = addr;
    assign wb_sdata    = sdata;
    assign wb_pc       = pc;
endmodule

// File: tb/tb_mem_wb_retire.sv
// tb_mem_wb_retire: directed vectors with a queued scoreboard checked by an independent monitor
module tb_mem_wb_retire;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0, freeze_i = 1'b0, flush_i = 1'b0;
    logic        m_valid = 1'b0, m_regwrite = 1'b0, m_memtoreg = 1'b0, m_memread = 1'b0;
    logic        m_memwrite = 1'b0, m_halt = 1'b0;
    logic [3:0]  m_dst = '0;
    logic [15:0] m_alu = '0, m_rdata = '0, m_wdata = '0, m_pc = '0;
    logic        wb_regwrite, wb_memread, wb_memwrite, hlt;
    logic [3:0]  wb_dst;
    logic [15:0] wb_data, wb_addr, wb_sdata, wb_pc;
    logic [31:0] inst_count, cycle_count;
    logic        n_regwrite, n_memread, n_memwrite, n_hlt;
    logic [3:0]  n_dst, n_inst, n_cycle;
    logic [15:0] n_data, n_addr, n_sdata, n_pc;

    always #5 clk = ~clk;

    mem_wb_retire #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .freeze_i(freeze_i), .flush_i(flush_i),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_memread(m_memread), .m_memwrite(m_memwrite), .m_halt(m_halt),
        .m_dst(m_dst), .m_alu(m_alu), .m_rdata(m_rdata), .m_wdata(m_wdata), .m_pc(m_pc),
        .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
        .wb_memread(wb_memread), .wb_memwrite(wb_memwrite), .wb_addr(wb_addr),
        .wb_sdata(wb_sdata), .wb_pc(wb_pc), .hlt(hlt),
        .inst_count(inst_count), .cycle_count(cycle_count)
    );

    // Narrow-counter copy sharing the stimulus, used for the wrap-around check
    mem_wb_retire #(.CNT_W(4)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .freeze_i(freeze_i), .flush_i(flush_i),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg),
        .m_memread(m_memread), .m_memwrite(m_memwrite), .m_halt(m_halt),
        .m_dst(m_dst), .m_alu(m_alu), .m_rdata(m_rdata), .m_wdata(m_wdata), .m_pc(m_pc),
        .wb_regwrite(n_regwrite), .wb_dst(n_dst), .wb_data(n_data),
        .wb_memread(n_memread), .wb_memwrite(n_memwrite), .wb_addr(n_addr),
        .wb_sdata(n_sdata), .wb_pc(n_pc), .hlt(n_hlt),
        .inst_count(n_inst), .cycle_count(n_cycle)
    );

    typedef struct {
        int           due;
        string        name;
        logic [143:0] v;
    } exp_t;

    exp_t         q[$];
    exp_t         m_e;
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [31:0]  ec = '0, ei = '0;
    logic         eh = 1'b0;
    logic [143:0] act;

    assign act = {wb_regwrite, wb_dst, wb_data, wb_memread, wb_memwrite, wb_addr, wb_sdata,
                  wb_pc, hlt, inst_count, cycle_count, n_inst, n_cycle};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due == cyc) begin
            m_e = q.pop_front();
            n_cmp++;
            if (act !== m_e.v) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", m_e.name, act, m_e.v);
            end
        end
    end

    task automatic mem(input logic v, rw, mtr, mr, mw, h, input logic [3:0] d,
                       input logic [15:0] alu, rd, wd, pc);
        m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_memread = mr;
        m_memwrite = mw; m_halt = h; m_dst = d;
        m_alu = alu; m_rdata = rd; m_wdata = wd; m_pc = pc;
    endtask

    // Applies control for one edge, pushes the outputs expected after that edge, then advances
    task automatic tick(input string nm, input logic rn, fz, fl, erw, input logic [3:0] ed,
                        input logic [15:0] edata, input logic emr, emw,
                        input logic [15:0] eaddr, esd, epc);
        exp_t e;
        rst_n = rn; freeze_i = fz; flush_i = fl;
        if (!rn) begin
            ec = '0; ei = '0; eh = 1'b0;
        end else if (!eh) begin
            ec = ec + 1;
            if (!fz && m_valid && !fl) begin
                if (m_regwrite | m_memwrite | m_halt) ei = ei + 1;
                if (m_halt) eh = 1'b1;
            end
        end
        e.due  = cyc + 1;
        e.name = nm;
        e.v    = {erw, ed, edata, emr, emw, eaddr, esd, epc, eh, ei, ec, ei[3:0], ec[3:0]};
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        mem(0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tick("reset", 0, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        mem(1, 1, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h5555, 16'h0000, 16'h0100);
        tick("alu_r3", 1, 0, 0, 1, 4'd3, 16'h1234, 0, 0, 16'h1234, 16'h0000, 16'h0100);
        mem(1, 1, 0, 0, 0, 0, 4'd4, 16'h00FF, 16'h0000, 16'h0007, 16'h0102);
        tick("alu_r4", 1, 0, 0, 1, 4'd4, 16'h00FF, 0, 0, 16'h00FF, 16'h0007, 16'h0102);
        mem(1, 1, 1, 1, 0, 0, 4'd5, 16'h0040, 16'hBEEF, 16'h0000, 16'h0104);
        tick("load_r5", 1, 0, 0, 1, 4'd5, 16'hBEEF, 1, 0, 16'h0040, 16'h0000, 16'h0104);
        mem(1, 1, 0, 0, 0, 0, 4'd0, 16'h0999, 16'h0000, 16'h0000, 16'h0106);
        tick("r0_write", 1, 0, 0, 0, 4'd0, 16'h0999, 0, 0, 16'h0999, 16'h0000, 16'h0106);
        mem(1, 1, 0, 0, 0, 0, 4'd7, 16'h7777, 16'h0000, 16'h0000, 16'h0108);
        tick("r7_capture", 1, 0, 0, 1, 4'd7, 16'h7777, 0, 0, 16'h7777, 16'h0000, 16'h0108);
        mem(1, 1, 0, 0, 0, 0, 4'd2, 16'h2222, 16'h0000, 16'h0000, 16'h010A);
        for (int i = 0; i < 3; i++)
            tick("r7_frozen", 1, 1, 0, 0, 4'd7, 16'h7777, 0, 0, 16'h7777, 16'h0000, 16'h0108);
        tick("unfreeze_r2", 1, 0, 0, 1, 4'd2, 16'h2222, 0, 0, 16'h2222, 16'h0000, 16'h010A);
        mem(1, 0, 0, 0, 1, 0, 4'd0, 16'h0010, 16'h0000, 16'hAAAA, 16'h010C);
        tick("flush_store", 1, 0, 1, 0, 4'd0, 16'h0010, 0, 0, 16'h0010, 16'hAAAA, 16'h010C);
        tick("store", 1, 0, 0, 0, 4'd0, 16'h0010, 0, 1, 16'h0010, 16'hAAAA, 16'h010C);
        mem(1, 1, 0, 0, 0, 0, 4'd9, 16'h9999, 16'h0000, 16'h0000, 16'h010E);
        tick("flush_freeze", 1, 1, 1, 0, 4'd0, 16'h0010, 0, 0, 16'h0010, 16'hAAAA, 16'h010C);
        tick("after_ff_r9", 1, 0, 0, 1, 4'd9, 16'h9999, 0, 0, 16'h9999, 16'h0000, 16'h010E);
        mem(1, 0, 0, 0, 0, 1, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0022);
        tick("halt_frozen", 1, 1, 0, 0, 4'd9, 16'h9999, 0, 0, 16'h9999, 16'h0000, 16'h010E);
        tick("halt_capture", 1, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0022);
        mem(1, 1, 0, 0, 0, 0, 4'd6, 16'h6666, 16'h0000, 16'h0000, 16'h0024);
        tick("halted_1", 1, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0022);
        tick("halted_2", 1, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0022);
        tick("reset_after_halt", 0, 0, 0, 0, 4'd0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        for (int i = 0; i < 17; i++) begin
            mem(1, 1, 0, 0, 0, 0, 4'd1, 16'(i), 16'h0000, 16'h0000, 16'(i));
            tick("wrap", 1, 0, 0, 1, 4'd1, 16'(i), 0, 0, 16'(i), 16'h0000, 16'(i));
        end
        mem(0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
